// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, line levels, baud helper.
package uart_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int unsigned calc_ticks(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer with a selectable reset level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / frame-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data_o,
    output logic       rx_data_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned TICKS = calc_ticks(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = TICKS / 2;
    localparam logic [15:0] BIT_TC  = 16'(TICKS - 1);
    localparam logic [15:0] HALF_TC = 16'(HALF - 1);

    generate
        if (TICKS < 4) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    uart_state_e r_state;
    uart_state_e w_next;

    logic        w_rx_s;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  w_bit_nxt;
    logic [7:0]  r_shreg;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_ferr;
    logic        w_shift;
    logic        w_valid;
    logic        w_ferr;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt + 16'd1;
        w_bit_nxt = r_bit_cnt;
        w_shift   = 1'b0;
        w_valid   = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (w_rx_s == START_BIT) begin
                    w_next = START;
                end
            end
            START: begin
                if (r_cnt == HALF_TC) begin
                    w_cnt_nxt = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    w_next = (w_rx_s == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (r_cnt == BIT_TC) begin
                    w_cnt_nxt = '0;
                    w_shift   = 1'b1;
                    w_bit_nxt = r_bit_cnt + 4'd1;
                    if (w_bit_nxt == 4'd8) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == BIT_TC) begin
                    w_cnt_nxt = '0;
                    w_valid   = (w_rx_s == STOP_BIT);
                    w_ferr    = (w_rx_s != STOP_BIT);
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_valid   <= w_valid;
            r_ferr    <= w_ferr;
            if (w_shift) begin
                r_shreg <= {w_rx_s, r_shreg[7:1]};
            end
            if (w_valid) begin
                r_data <= r_shreg;
            end
        end
    end

    assign rx_data_o     = r_data;
    assign rx_data_valid = r_valid;
    assign rx_frame_err  = r_ferr;
    assign rx_busy       = (r_state != IDLE);

endmodule
